// File: rtl/bus_xfer_ctrl_if.sv
// rtl/bus_xfer_ctrl_if.sv - command handshake and bus-control signal bundle for bus_xfer_ctrl
interface bus_xfer_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_src;
    logic [4:0]  cmd_dst;
    logic [4:0]  bus_sel;
    logic [24:0] dst_load;
    logic        xfer_done;
    logic        err_src;
    logic        err_dst;
    logic        busy;

    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, bus_sel, dst_load, xfer_done, err_src, err_dst, busy
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, bus_sel, dst_load, xfer_done, err_src, err_dst, busy
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - queued register-transfer controller driving bus source select and destination loads
module bus_xfer_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           reset,
    bus_xfer_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_LOAD} state_t;

    state_t        state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [4:0]    src_q, src_d;
    logic [4:0]    dst_q, dst_d;
    logic [4:0]    bus_sel_q, bus_sel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          full, empty, push, pop;
    logic          src_ok, dst_ok;
    logic [24:0]   dst_load;
    logic          xfer_done, err_src, err_dst;

    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign push   = bus.cmd_valid && !full;
    assign pop    = (state_q == S_IDLE) && !empty;

    // Holes in the source map (22, 23, 25-30) have no driver on the bus mux.
    assign src_ok = (src_q <= 5'd21) || (src_q == 5'd24) || (src_q == 5'd31);
    assign dst_ok = (dst_q <= 5'd24);

    always_comb begin : fifo_next
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_src, bus.cmd_dst};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        bus_sel_d = bus_sel_q;
        cnt_d     = cnt_q;
        dst_load  = '0;
        xfer_done = 1'b0;
        err_src   = 1'b0;
        err_dst   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {src_d, dst_d} = mem_q[rd_ptr_q];
                    state_d        = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!src_ok || !dst_ok) begin
                    err_src = !src_ok;
                    err_dst = !dst_ok;
                    state_d = S_IDLE;
                end else begin
                    bus_sel_d = src_q;
                    cnt_d     = '0;
                    state_d   = (SETTLE == 0) ? S_LOAD : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                dst_load  = 25'(1) << dst_q;
                xfer_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            bus_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            bus_sel_q <= bus_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Entry storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // bus_sel_d equals bus_sel_q except in DRIVE, so the mux sees the source in DRIVE itself.
    assign bus.cmd_ready = !full;
    assign bus.bus_sel   = bus_sel_d;
    assign bus.dst_load  = dst_load;
    assign bus.xfer_done = xfer_done;
    assign bus.err_src   = err_src;
    assign bus.err_dst   = err_dst;
    assign bus.busy      = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl with a transaction-timeline reference model
module tb_bus_xfer_ctrl;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if bif ();
    bus_xfer_ctrl_if bif0 ();

    bus_xfer_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    bus_xfer_ctrl #(.DEPTH(DEPTH), .SETTLE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif0)
    );

    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
    } cmd_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending commands plus the one in flight and the cycle it was popped.
    cmd_t       mq[$];
    cmd_t       m_cur;
    bit         m_active;
    int         m_ps;
    logic [4:0] m_last;
    int         cyc;

    logic [4:0]  o_sel;
    logic [24:0] o_load;
    logic        o_done, o_es, o_ed, o_busy, o_rdy;
    bit          saw_both;
    logic [24:0] load_acc;
    int          lat;

    function automatic bit src_ok(input logic [4:0] s);
        return (s < 5'd16) || (s inside {5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd24, 5'd31});
    endfunction

    function automatic bit dst_ok(input logic [4:0] d);
        return d <= 5'd24;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [4:0] s, input logic [4:0] d);
        logic [4:0]  e_sel;
        logic [24:0] e_load;
        bit          e_done, e_es, e_ed, e_busy, e_rdy, fin, was_idle;
        int          k;
        cmd_t        c;
        @(negedge clk);
        reset         = rst;
        bif.cmd_valid = v;
        bif.cmd_src   = s;
        bif.cmd_dst   = d;
        #1;
        o_sel  = bif.bus_sel;
        o_load = bif.dst_load;
        o_done = bif.xfer_done;
        o_es   = bif.err_src;
        o_ed   = bif.err_dst;
        o_busy = bif.busy;
        o_rdy  = bif.cmd_ready;
        if (o_es && o_ed) saw_both = 1'b1;
        load_acc = load_acc | o_load;

        e_sel    = m_last;
        e_load   = '0;
        e_done   = 1'b0;
        e_es     = 1'b0;
        e_ed     = 1'b0;
        e_busy   = m_active || (mq.size() != 0);
        e_rdy    = (mq.size() < DEPTH);
        fin      = 1'b0;
        was_idle = !m_active;
        if (m_active) begin
            k = cyc - m_ps;
            if (k == 1) begin
                if (!src_ok(m_cur.src) || !dst_ok(m_cur.dst)) begin
                    e_es = !src_ok(m_cur.src);
                    e_ed = !dst_ok(m_cur.dst);
                    fin  = 1'b1;
                end else begin
                    e_sel  = m_cur.src;
                    m_last = m_cur.src;
                end
            end else if (k == 2 + SETTLE) begin
                e_load = 25'd1 << m_cur.dst;
                e_done = 1'b1;
                fin    = 1'b1;
            end
        end

        check("bus_sel",   32'(o_sel),  32'(e_sel));
        check("dst_load",  32'(o_load), 32'(e_load));
        check("xfer_done", 32'(o_done), 32'(e_done));
        check("err_src",   32'(o_es),   32'(e_es));
        check("err_dst",   32'(o_ed),   32'(e_ed));
        check("busy",      32'(o_busy), 32'(e_busy));
        check("cmd_ready", 32'(o_rdy),  32'(e_rdy));

        if (fin) m_active = 1'b0;
        if (was_idle && mq.size() != 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_ps     = cyc;
        end
        if (v && e_rdy) begin
            c.src = s;
            c.dst = d;
            mq.push_back(c);
        end
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_last   = '0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bif.cmd_valid  = 1'b0;
        bif.cmd_src    = '0;
        bif.cmd_dst    = '0;
        bif0.cmd_valid = 1'b0;
        bif0.cmd_src   = '0;
        bif0.cmd_dst   = '0;
        m_active       = 1'b0;
        m_ps           = 0;
        m_last         = '0;
        cyc            = 0;
        saw_both       = 1'b0;
        load_acc       = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bus_sel",   32'(bif.bus_sel),   32'd0);
        check("rst_dst_load",  32'(bif.dst_load),  32'd0);
        check("rst_xfer_done", 32'(bif.xfer_done), 32'd0);
        check("rst_err",       32'({bif.err_src, bif.err_dst}), 32'd0);
        check("rst_busy",      32'(bif.busy),      32'd0);
        check("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        check("rst0_cmd_ready", 32'(bif0.cmd_ready), 32'd1);

        // R5 -> HI: load on the 4th cycle after the push cycle
        step(1'b0, 1'b1, 5'd5, 5'd16);
        idle(3);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        check("t1_load_hi", 32'(o_load), 32'h0010000);
        check("t1_done",    32'(o_done), 32'd1);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        check("t1_busy_drop", 32'(o_busy), 32'd0);

        // Fill the FIFO behind a running transfer, then one push too many
        step(1'b0, 1'b1, 5'd0,  5'd0);
        step(1'b0, 1'b1, 5'd21, 5'd1);
        step(1'b0, 1'b1, 5'd20, 5'd2);
        step(1'b0, 1'b1, 5'd31, 5'd3);
        step(1'b0, 1'b1, 5'd24, 5'd20);
        step(1'b0, 1'b1, 5'd7,  5'd7);
        check("t2_full_ready", 32'(o_rdy), 32'd0);
        idle(20);

        // Illegal source followed by a good command
        step(1'b0, 1'b1, 5'd22, 5'd3);
        step(1'b0, 1'b1, 5'd0,  5'd19);
        idle(10);

        // Illegal destination, then both illegal together
        step(1'b0, 1'b1, 5'd1, 5'd27);
        idle(5);
        step(1'b0, 1'b1, 5'd25, 5'd30);
        idle(5);
        check("t4_both_err", 32'(saw_both), 32'd1);

        // Reset while the first transfer sits in SETTLE with two more queued
        step(1'b0, 1'b1, 5'd2, 5'd4);
        step(1'b0, 1'b1, 5'd3, 5'd5);
        step(1'b0, 1'b1, 5'd6, 5'd7);
        step(1'b1, 1'b0, 5'd0, 5'd0);
        load_acc = '0;
        step(1'b0, 1'b0, 5'd0, 5'd0);
        check("t5_busy",  32'(o_busy), 32'd0);
        check("t5_ready", 32'(o_rdy),  32'd1);
        idle(6);
        check("t5_no_load", 32'(load_acc), 32'd0);

        // Push and pop in the same cycle at DEPTH-1 occupancy
        step(1'b0, 1'b1, 5'd8,  5'd8);
        step(1'b0, 1'b1, 5'd9,  5'd9);
        step(1'b0, 1'b1, 5'd10, 5'd10);
        step(1'b0, 1'b1, 5'd11, 5'd11);
        step(1'b0, 1'b0, 5'd0,  5'd0);
        step(1'b0, 1'b1, 5'd12, 5'd12);
        idle(20);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            bit         rv, rr;
            logic [4:0] rs, rd;
            rv = ($urandom_range(0, 9) < 4);
            rs = 5'($urandom_range(0, 31));
            rd = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
            rr = ($urandom_range(0, 149) == 0);
            step(rr, rv, rs, rd);
        end
        idle(30);

        // SETTLE=0 instance: latency of 3 cycles from the push cycle
        @(negedge clk);
        bif0.cmd_valid = 1'b1;
        bif0.cmd_src   = 5'd9;
        bif0.cmd_dst   = 5'd22;
        @(negedge clk);
        bif0.cmd_valid = 1'b0;
        lat = 1;
        #1;
        while (bif0.dst_load == '0 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("s0_latency", 32'(lat), 32'd3);
        check("s0_load",    32'(bif0.dst_load), 32'h0400000);
        check("s0_bus_sel", 32'(bif0.bus_sel), 32'd9);
        check("s0_done",    32'(bif0.xfer_done), 32'd1);
        @(negedge clk);
        #1;
        check("s0_busy", 32'(bif0.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
